// File: rtl/ball_motion_engine.sv
// ball_motion_engine: per-ball fixed-point trajectory integrator with reflection and cushion clamp.
// Rolling friction and rest detection are compiled in with `define BALL_FRICTION_EN.
module ball_motion_engine #(
  parameter int FRAC_BITS = 6,
  parameter int POS_W     = 11,
  parameter int SPEED_W   = 16,
  parameter int INITIAL_X = 400,
  parameter int INITIAL_Y = 220,
  parameter int FRICTION  = 1,
  parameter int MIN_SPEED = 2,
  parameter int MAX_SPEED = 1023,
  parameter int X_MIN     = 32,
  parameter int X_MAX     = 576,
  parameter int Y_MIN     = 32,
  parameter int Y_MAX     = 416
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      shotValid,
  output logic                      shotReady,
  input  logic signed [SPEED_W-1:0] shotXSpeed,
  input  logic signed [SPEED_W-1:0] shotYSpeed,
  input  logic                      collision,
  input  logic [3:0]                HitEdgeCode,
  input  logic                      respawn,
  output logic signed [POS_W-1:0]   topLeftX,
  output logic signed [POS_W-1:0]   topLeftY,
  output logic                      moving,
  output logic                      stopPulse
);
  localparam int PW = POS_W + FRAC_BITS + 1;
  typedef logic signed [PW-1:0] pos_t;
  typedef logic signed [SPEED_W-1:0] spd_t;
  typedef enum logic [1:0] {IDLE, ROLLING, RESPAWN} state_t;
`ifdef BALL_FRICTION_EN
  localparam bit FRIC_EN = 1'b1;
`else
  localparam bit FRIC_EN = 1'b0;
`endif
  localparam spd_t S_MAX    = spd_t'({1'b0, {(SPEED_W-1){1'b1}}});
  localparam spd_t S_MIN    = ~S_MAX;
  localparam spd_t SHOT_MAX = spd_t'(MAX_SPEED);
  localparam pos_t INIT_X   = pos_t'(INITIAL_X <<< FRAC_BITS);
  localparam pos_t INIT_Y   = pos_t'(INITIAL_Y <<< FRAC_BITS);
  localparam pos_t LO_X     = pos_t'(X_MIN <<< FRAC_BITS);
  localparam pos_t HI_X     = pos_t'(X_MAX <<< FRAC_BITS);
  localparam pos_t LO_Y     = pos_t'(Y_MIN <<< FRAC_BITS);
  localparam pos_t HI_Y     = pos_t'(Y_MAX <<< FRAC_BITS);

  function automatic spd_t neg(spd_t s);
    return (s == S_MIN) ? S_MAX : -s;
  endfunction

  function automatic spd_t mag(spd_t s);
    return s[SPEED_W-1] ? neg(s) : s;
  endfunction

  function automatic spd_t reflect(spd_t s, logic neg_edge, logic pos_edge);
    return ((neg_edge && s[SPEED_W-1]) || (pos_edge && !s[SPEED_W-1] && s != '0)) ? neg(s) : s;
  endfunction

  function automatic spd_t fric(spd_t s);
    spd_t t;
    t = s[SPEED_W-1] ? s + spd_t'(FRICTION) : (s != '0) ? s - spd_t'(FRICTION) : s;
    return !FRIC_EN ? s : (mag(t) <= spd_t'(MIN_SPEED)) ? '0 : t;
  endfunction

  function automatic pos_t clamp_pos(pos_t p, pos_t lo, pos_t hi);
    return (p < lo) ? lo : (p > hi) ? hi : p;
  endfunction

  function automatic spd_t clamp_spd(pos_t p, spd_t s, pos_t lo, pos_t hi);
    return (p < lo) ? mag(s) : (p > hi) ? neg(mag(s)) : s;
  endfunction

  function automatic spd_t clamp_shot(spd_t s);
    return (s > SHOT_MAX) ? SHOT_MAX : (s < -SHOT_MAX) ? -SHOT_MAX : s;
  endfunction

  state_t state_q, state_d;
  pos_t   px_q, px_d, py_q, py_d, nx, ny;
  spd_t   sx_q, sx_d, sy_q, sy_d, cx, cy;
  logic   stop_q, stop_d;

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    stop_d  = 1'b0;
    cx      = collision ? reflect(sx_q, HitEdgeCode[3], HitEdgeCode[1]) : sx_q;
    cy      = collision ? reflect(sy_q, HitEdgeCode[2], HitEdgeCode[0]) : sy_q;
    nx      = px_q + pos_t'(sx_q);
    ny      = py_q + pos_t'(sy_q);
    if (respawn) begin
      state_d = RESPAWN;
      px_d    = INIT_X;
      py_d    = INIT_Y;
      sx_d    = '0;
      sy_d    = '0;
    end else if (state_q == IDLE) begin
      if (shotValid) begin
        sx_d    = clamp_shot(shotXSpeed);
        sy_d    = clamp_shot(shotYSpeed);
        state_d = (sx_d != '0 || sy_d != '0) ? ROLLING : IDLE;
      end
    end else if (state_q == ROLLING) begin
      // position integrates with the pre-reflection speed; friction acts on the reflected one
      if (startOfFrame) begin
        px_d = clamp_pos(nx, LO_X, HI_X);
        py_d = clamp_pos(ny, LO_Y, HI_Y);
        sx_d = clamp_spd(nx, fric(cx), LO_X, HI_X);
        sy_d = clamp_spd(ny, fric(cy), LO_Y, HI_Y);
        stop_d  = (sx_d == '0 && sy_d == '0);
        state_d = stop_d ? IDLE : ROLLING;
      end else begin
        sx_d = cx;
        sy_d = cy;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      px_q    <= INIT_X;
      py_q    <= INIT_Y;
      sx_q    <= '0;
      sy_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      stop_q  <= stop_d;
    end
  end

  assign topLeftX  = POS_W'(px_q >>> FRAC_BITS);
  assign topLeftY  = POS_W'(py_q >>> FRAC_BITS);
  assign shotReady = (state_q == IDLE);
  assign moving    = (state_q == ROLLING);
  assign stopPulse = stop_q;
endmodule

// File: tb/tb_ball_motion_engine.sv
// tb_ball_motion_engine: directed and randomized checks of ball_motion_engine against an integer model.
module tb_ball_motion_engine;
  logic clk = 1'b0, resetN = 1'b0;
  logic startOfFrame = 1'b0, shotValid = 1'b0, collision = 1'b0, respawn = 1'b0;
  logic shotReady, moving, stopPulse;
  logic signed [15:0] shotXSpeed = '0, shotYSpeed = '0;
  logic [3:0] HitEdgeCode = '0;
  logic signed [10:0] topLeftX, topLeftY;
  logic [24:0] obs;
  int cmp = 0, fails = 0;
  int mpx, mpy, mvx, mvy, mmode;
  bit mstop;

  ball_motion_engine dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .shotValid(shotValid),
    .shotReady(shotReady), .shotXSpeed(shotXSpeed), .shotYSpeed(shotYSpeed),
    .collision(collision), .HitEdgeCode(HitEdgeCode), .respawn(respawn),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .moving(moving), .stopPulse(stopPulse)
  );

  always #5 clk = ~clk;
  assign obs = {shotReady, moving, stopPulse, topLeftX, topLeftY};

  function automatic logic [24:0] expv();
    return {mmode == 0, mmode == 1, mstop, 11'(mpx >>> 6), 11'(mpy >>> 6)};
  endfunction

  function automatic int sat(int s);
    return s > 1023 ? 1023 : s < -1023 ? -1023 : s;
  endfunction

  function automatic int fr(int s);
    int t;
`ifdef BALL_FRICTION_EN
    t = s > 0 ? s - 1 : s < 0 ? s + 1 : 0;
    return (t <= 2 && t >= -2) ? 0 : t;
`else
    t = s;
    return t;
`endif
  endfunction

  task automatic bounce(inout int p, inout int s, input int lo, input int hi);
    if (p < lo * 64) begin p = lo * 64; s = s < 0 ? -s : s; end
    else if (p > hi * 64) begin p = hi * 64; s = s > 0 ? -s : s; end
  endtask

  task automatic model_reset();
    mmode = 0; mpx = 400 * 64; mpy = 220 * 64; mvx = 0; mvy = 0; mstop = 0;
  endtask

  // mode: 0 idle, 1 rolling, 2 respawn
  task automatic model(input bit f, input bit c, input logic [3:0] e, input bit v, input int sx, input int sy, input bit r);
    int rx, ry;
    mstop = 0;
    if (r) begin
      mmode = 2; mpx = 400 * 64; mpy = 220 * 64; mvx = 0; mvy = 0;
    end else if (mmode == 0) begin
      if (v) begin
        mvx = sat(sx); mvy = sat(sy);
        if (mvx != 0 || mvy != 0) mmode = 1;
      end
    end else if (mmode == 2) begin
      mmode = 0;
    end else begin
      rx = (c && ((e[3] && mvx < 0) || (e[1] && mvx > 0))) ? -mvx : mvx;
      ry = (c && ((e[2] && mvy < 0) || (e[0] && mvy > 0))) ? -mvy : mvy;
      if (f) begin
        mpx += mvx; mpy += mvy;
        rx = fr(rx); ry = fr(ry);
        bounce(mpx, rx, 32, 576);
        bounce(mpy, ry, 32, 416);
        if (rx == 0 && ry == 0) begin mmode = 0; mstop = 1; end
      end
      mvx = rx; mvy = ry;
    end
  endtask

  task automatic step(input bit f, input bit c, input logic [3:0] e, input bit v, input int sx, input int sy, input bit r);
    startOfFrame = f; collision = c; HitEdgeCode = e; shotValid = v;
    shotXSpeed = 16'(sx); shotYSpeed = 16'(sy); respawn = r;
    @(posedge clk);
    model(f, c, e, v, sx, sy, r);
    #1;
    startOfFrame = 0; collision = 0; shotValid = 0; respawn = 0;
  endtask

  task automatic go_home();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if (obs !== {1'b1, 1'b0, 1'b0, 11'sd400, 11'sd220}) begin
      fails++; $display("FAIL reset_in obs=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 11'sd400, 11'sd220});
    end
    cmp++;
    resetN = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    if (obs !== expv()) begin fails++; $display("FAIL reset_out obs=%h exp=%h", obs, expv()); end
    cmp++;
  endtask

  task automatic test_shot_friction();
    bit stopped = 0;
    step(0, 0, 0, 1, 128, 0, 0);
    if (shotReady !== 1'b0 || moving !== 1'b1) begin
      fails++; $display("FAIL shot_accept ready=%b moving=%b exp 0 1", shotReady, moving);
    end
    cmp++;
    step(1, 0, 0, 0, 0, 0, 0);
    if (topLeftX !== 11'sd402) begin fails++; $display("FAIL first_frame x=%0d exp=402", topLeftX); end
    cmp++;
    for (int k = 0; k < 300 && !stopped; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      if (obs !== expv()) begin fails++; $display("FAIL roll k=%0d obs=%h exp=%h", k, obs, expv()); end
      cmp++;
      stopped = mstop;
    end
`ifdef BALL_FRICTION_EN
    if (!(stopPulse === 1'b1 && moving === 1'b0 && topLeftX === 11'sd528 && topLeftY === 11'sd220)) begin
      fails++; $display("FAIL rest stop=%b moving=%b x=%0d y=%0d exp 1 0 528 220", stopPulse, moving, topLeftX, topLeftY);
    end
    cmp++;
    step(0, 0, 0, 0, 0, 0, 0);
    if (stopPulse !== 1'b0) begin fails++; $display("FAIL stop_once stop=%b exp=0", stopPulse); end
    cmp++;
`else
    if (moving !== 1'b1) begin fails++; $display("FAIL no_friction_roll moving=%b exp=1", moving); end
    cmp++;
`endif
    go_home();
  endtask

  task automatic test_shot_clamp();
    bit hx = 0, hy = 0, dx = 0, dy = 0;
    step(0, 0, 0, 1, 5000, -5000, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    if (topLeftX !== 11'sd415 || topLeftY !== 11'sd204) begin
      fails++; $display("FAIL shot_sat x=%0d y=%0d exp 415 204", topLeftX, topLeftY);
    end
    cmp++;
    for (int k = 0; k < 40; k++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      if (obs !== expv() || topLeftX > 576 || topLeftY < 32) begin
        fails++; $display("FAIL clamp k=%0d obs=%h exp=%h", k, obs, expv());
      end
      cmp++;
      if (hx && !dx) begin
        dx = 1;
        if (topLeftX >= 576) begin fails++; $display("FAIL x_flip x=%0d exp <576", topLeftX); end
        cmp++;
      end
      if (hy && !dy) begin
        dy = 1;
        if (topLeftY <= 32) begin fails++; $display("FAIL y_flip y=%0d exp >32", topLeftY); end
        cmp++;
      end
      hx = hx || topLeftX == 576;
      hy = hy || topLeftY == 32;
    end
    if (!(dx && dy)) begin fails++; $display("FAIL clamp_seen x=%0b y=%0b exp 1 1", dx, dy); end
    cmp++;
    go_home();
  endtask

  task automatic test_reflect();
    step(0, 0, 0, 1, 100, 0, 0);
    step(0, 1, 4'b0010, 0, 0, 0, 0);
    step(0, 1, 4'b0010, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    if (topLeftX !== 11'sd398 || obs !== expv()) begin
      fails++; $display("FAIL reflect x=%0d exp=398 obs=%h exp=%h", topLeftX, obs, expv());
    end
    cmp++;
    go_home();
  endtask

  task automatic test_coll_frame();
    step(0, 0, 0, 1, 0, 64, 0);
    step(1, 1, 4'b0001, 0, 0, 0, 0);
    if (topLeftY !== 11'sd221) begin fails++; $display("FAIL coll_frame_pos y=%0d exp=221", topLeftY); end
    cmp++;
    step(1, 0, 0, 0, 0, 0, 0);
    if (topLeftY !== 11'sd220 || obs !== expv()) begin
      fails++; $display("FAIL coll_frame_spd y=%0d exp=220 obs=%h exp=%h", topLeftY, obs, expv());
    end
    cmp++;
    go_home();
  endtask

  task automatic test_respawn();
    step(0, 0, 0, 1, 200, 200, 1);
    if (obs !== {1'b0, 1'b0, 1'b0, 11'sd400, 11'sd220}) begin
      fails++; $display("FAIL respawn_shot obs=%h exp=%h", obs, {1'b0, 1'b0, 1'b0, 11'sd400, 11'sd220});
    end
    cmp++;
    step(0, 0, 0, 0, 0, 0, 0);
    if (obs !== {1'b1, 1'b0, 1'b0, 11'sd400, 11'sd220}) begin
      fails++; $display("FAIL respawn_idle obs=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 11'sd400, 11'sd220});
    end
    cmp++;
    step(0, 0, 0, 1, 300, -300, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    if (obs !== {1'b0, 1'b0, 1'b0, 11'sd400, 11'sd220} || obs !== expv()) begin
      fails++; $display("FAIL respawn_roll obs=%h exp=%h", obs, expv());
    end
    cmp++;
    step(0, 0, 0, 0, 0, 0, 0);
    if (stopPulse !== 1'b0 || obs !== expv()) begin fails++; $display("FAIL respawn_nostop obs=%h exp=%h", obs, expv()); end
    cmp++;
  endtask

  task automatic test_reset_midroll();
    step(0, 0, 0, 1, 500, 400, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0, 0);
    #2 resetN = 0;
    model_reset();
    #1;
    if (obs !== {1'b1, 1'b0, 1'b0, 11'sd400, 11'sd220}) begin
      fails++; $display("FAIL reset_midroll obs=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 11'sd400, 11'sd220});
    end
    cmp++;
    @(posedge clk);
    #1 resetN = 1;
  endtask

  task automatic test_random();
    bit f, c, v, r;
    int sx, sy;
    for (int i = 0; i < 3000; i++) begin
      f = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 99) == 0);
      sx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 6000)) - 3000;
      sy = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 6000)) - 3000;
      step(f, c, 4'($urandom), v, sx, sy, r);
      if (obs !== expv()) begin fails++; $display("FAIL random i=%0d obs=%h exp=%h", i, obs, expv()); end
      cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_shot_friction();
    test_shot_clamp();
    test_reflect();
    test_coll_frame();
    test_respawn();
    test_reset_midroll();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
